instr_sequencer: RTL and testbench

Fetch/issue sequencer for the accumulator core: fetches instruction words from instruction memory and presents the 6-bit opcode to the control unit. It then consumes the returned 8-bit control word (next, br/oth, aluOp, lse, ldm, lacc, abs, spo) to drive datapath strobes and update the PC. It sits between instruction memory and the control unit, forming the issuing side of the opcode/control-word interface.

---
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 tb/tb_instr_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec issue sequencer for the accumulator core.
// Optional 4-entry return stack for jmp/ret is enabled by defining RET_STACK_EN.
module instr_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [5:0]         opcode,
  output logic [ADDR_W-1:0]  operand,
  input  logic [7:0]         ctrl,
  input  logic [3:0]         flags,
  output logic               alu_en,
  output logic               ext_en,
  output logic               mem_ld_en,
  output logic               acc_we,
  output logic               mem_st_en,
  output logic               halt,
  output logic               illegal
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic [5:0]        opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] pc_inc, br_target;
  logic              cond, taken, fault;
`ifdef RET_STACK_EN
  logic [ADDR_W-1:0] stk_q [4];
  logic [ADDR_W-1:0] stk_d [4];
  logic [2:0]        sp_q, sp_d;
`endif

  assign imem_addr = pc_q;
  assign imem_rd   = (state_q == S_FETCH);
  assign opcode    = opcode_q;
  assign operand   = operand_q;
  assign halt      = (state_q == S_HALT);
  assign illegal   = illegal_q;

  // The operand is already ADDR_W wide, so a modular add is the sign-extended relative branch.
  always_comb begin
    pc_inc    = pc_q + ADDR_W'(1);
    br_target = ctrl[1] ? operand_q : pc_q + operand_q;
    case (opcode_q)
      6'd2:             cond = flags[3];
      6'd3:             cond = flags[2];
      6'd4:             cond = flags[1];
      6'd5:             cond = flags[0];
      6'd6, 6'd7, 6'd8: cond = 1'b1;
      default:          cond = 1'b0;
    endcase
    taken = ctrl[6] & cond;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    fault     = 1'b0;
    alu_en    = 1'b0;
    ext_en    = 1'b0;
    mem_ld_en = 1'b0;
    acc_we    = 1'b0;
    mem_st_en = 1'b0;
`ifdef RET_STACK_EN
    stk_d = stk_q;
    sp_d  = sp_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          opcode_d  = imem_rdata[INSTR_W-1 -: 6];
          operand_d = imem_rdata[ADDR_W-1:0];
          state_d   = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        fault = (ctrl == 8'hFF);
        pc_d  = taken ? br_target : pc_inc;
`ifdef RET_STACK_EN
        if (!fault && opcode_q == 6'd7) begin
          if (sp_q == 3'd4) begin
            fault = 1'b1;
          end else begin
            stk_d[sp_q[1:0]] = pc_inc;
            sp_d             = sp_q + 3'd1;
          end
        end else if (!fault && opcode_q == 6'd8) begin
          if (sp_q == 3'd0) begin
            fault = 1'b1;
          end else begin
            pc_d = stk_q[sp_q[1:0] - 2'd1];
            sp_d = sp_q - 3'd1;
          end
        end
`else
        if (opcode_q == 6'd8) fault = 1'b1;
`endif
        // A faulting instruction leaves PC where it was and fires no strobes.
        if (fault) begin
          pc_d      = pc_q;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          alu_en    = ctrl[5];
          ext_en    = ctrl[4];
          mem_ld_en = ctrl[3];
          acc_we    = ctrl[2];
          mem_st_en = (opcode_q == 6'd1);
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      illegal_q <= 1'b0;
`ifdef RET_STACK_EN
      sp_q <= '0;
      for (int i = 0; i < 4; i++) stk_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      illegal_q <= illegal_d;
`ifdef RET_STACK_EN
      sp_q  <= sp_d;
      stk_q <= stk_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a program-level reference model.
module tb_instr_sequencer;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               imem_valid = 1'b0;
  logic [5:0]         opcode;
  logic [ADDR_W-1:0]  operand;
  logic [7:0]         ctrl = '0;
  logic [3:0]         flags = '0;
  logic alu_en, ext_en, mem_ld_en, acc_we, mem_st_en, halt, illegal;

  instr_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .opcode(opcode), .operand(operand),
    .ctrl(ctrl), .flags(flags), .alu_en(alu_en), .ext_en(ext_en), .mem_ld_en(mem_ld_en),
    .acc_we(acc_we), .mem_st_en(mem_st_en), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [4:0] strb = {alu_en, ext_en, mem_ld_en, acc_we, mem_st_en};

  typedef struct {
    logic [9:0] fetch;
    logic [9:0] next;
    logic [9:0] opd;
    logic [5:0] op;
    logic [4:0] strb;
    logic       fault;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] stk_m[$];
  logic [9:0] pc_m = '0;
  logic       last_fault = 1'b0;
  int         checks = 0;
  int         failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: computes the architectural effect of one instruction, then drives it.
  task automatic issue(input logic [5:0] op, input logic [9:0] opd, input logic [7:0] c,
                       input logic [3:0] f, input int dly);
    exp_t e;
    logic cnd;
    logic [9:0] dest;
    e.fetch = pc_m;
    e.op    = op;
    e.opd   = opd;
    e.fault = (c == 8'hFF);
    cnd = 1'b0;
    if (op == 6'd2) cnd = f[3];
    else if (op == 6'd3) cnd = f[2];
    else if (op == 6'd4) cnd = f[1];
    else if (op == 6'd5) cnd = f[0];
    else if (op >= 6'd6 && op <= 6'd8) cnd = 1'b1;
    dest   = c[1] ? opd : 10'(pc_m + opd);
    e.next = (c[6] && cnd) ? dest : 10'(pc_m + 10'd1);
    if (!e.fault) begin
`ifdef RET_STACK_EN
      if (op == 6'd7) begin
        if (stk_m.size() == 4) e.fault = 1'b1;
        else stk_m.push_back(10'(pc_m + 10'd1));
      end
      if (op == 6'd8) begin
        if (stk_m.size() == 0) e.fault = 1'b1;
        else e.next = stk_m.pop_back();
      end
`else
      if (op == 6'd8) e.fault = 1'b1;
`endif
    end
    if (e.fault) e.next = pc_m;
    e.strb = e.fault ? 5'b0 : {c[5], c[4], c[3], c[2], op == 6'd1};
    exp_q.push_back(e);
    pc_m       = e.next;
    last_fault = e.fault;
    ctrl  = c;
    flags = f;
    for (int i = 0; i < dly; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    imem_valid = 1'b1;
    imem_rdata = {op, opd};
    @(posedge clk); #1;
    repeat (2) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    imem_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pc_m = '0;
    stk_m.delete();
    exp_q.delete();
  endtask

  // Monitor: pops an expectation on each accepted fetch and follows it through DECODE/EXEC.
  int   phase = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (phase == 3) begin
        chk("post_halt", 32'(halt), 32'(cur.fault));
        chk("post_illegal", 32'(illegal), 32'(cur.fault));
        chk("post_rd", 32'(imem_rd), 32'(!cur.fault));
        chk("next_pc", 32'(imem_addr), 32'(cur.next));
        phase = 0;
      end else if (phase == 2) begin
        chk("exec_strobes", 32'(strb), 32'(cur.strb));
        chk("exec_opcode", 32'(opcode), 32'(cur.op));
        chk("exec_rd", 32'(imem_rd), 32'd0);
        phase = 3;
      end else if (phase == 1) begin
        chk("dec_opcode", 32'(opcode), 32'(cur.op));
        chk("dec_operand", 32'(operand), 32'(cur.opd));
        chk("dec_strobes", 32'(strb), 32'd0);
        chk("dec_rd", 32'(imem_rd), 32'd0);
        phase = 2;
      end
      if (phase == 0) begin
        chk("idle_strobes", 32'(strb), 32'd0);
        if (imem_rd && imem_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fetch", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("fetch_addr", 32'(imem_addr), 32'(cur.fetch));
            phase = 1;
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [7:0] c;
    do_reset();
    chk("rst_rd", 32'(imem_rd), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);

    issue(6'd9, 10'h000, 8'hA4, 4'h0, 0);
    chk("add_pc", 32'(imem_addr), 32'd1);

    issue(6'd6, 10'h005, 8'h42, 4'h0, 1);
    issue(6'd2, 10'h3FE, 8'h40, 4'h8, 2);
    chk("brz_taken", 32'(imem_addr), 32'd3);
    issue(6'd6, 10'h005, 8'h42, 4'h0, 0);
    issue(6'd2, 10'h3FE, 8'h40, 4'h7, 0);
    chk("brz_not_taken", 32'(imem_addr), 32'd6);
    issue(6'd6, 10'h120, 8'h42, 4'h0, 3);
    chk("bra_abs", 32'(imem_addr), 32'h120);
    issue(6'd6, 10'h3FF, 8'h42, 4'h0, 0);
    issue(6'd0, 10'h155, 8'h00, 4'hF, 0);
    chk("pc_wrap", 32'(imem_addr), 32'd0);
    issue(6'd1, 10'h010, 8'h08, 4'h0, 0);

    issue(6'h3F, 10'h000, 8'hFF, 4'h0, 0);
    repeat (4) begin
      imem_valid = 1'b1;
      imem_rdata = 16'($urandom);
      @(posedge clk); #1;
      chk("halt_sticky", 32'({halt, illegal, imem_rd, strb}), 32'({1'b1, 1'b1, 1'b0, 5'b0}));
    end
    do_reset();
    chk("rst_clear_flags", 32'({halt, illegal}), 32'd0);
    chk("rst_clear_pc", 32'(imem_addr), 32'd0);

    // Reset during an outstanding fetch: valid arriving while rst is high must be dropped.
    issue(6'd6, 10'h055, 8'h42, 4'h0, 0);
    imem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_valid = 1'b1;
    imem_rdata = {6'd9, 10'h2AA};
    @(posedge clk); #1;
    rst = 1'b0;
    imem_valid = 1'b0;
    pc_m = '0;
    stk_m.delete();
    exp_q.delete();
    chk("midfetch_rst_addr", 32'(imem_addr), 32'd0);
    chk("midfetch_rst_opcode", 32'(opcode), 32'd0);
    @(posedge clk); #1;
    chk("midfetch_still_fetch", 32'(imem_rd), 32'd1);
    issue(6'd9, 10'h000, 8'h24, 4'h0, 1);
    chk("midfetch_restart", 32'(imem_addr), 32'd1);

`ifdef RET_STACK_EN
    do_reset();
    issue(6'd6, 10'h010, 8'h42, 4'h0, 0);
    issue(6'd7, 10'h040, 8'h42, 4'h0, 0);
    chk("jmp_target", 32'(imem_addr), 32'h40);
    issue(6'd8, 10'h123, 8'h00, 4'h0, 0);
    chk("ret_target", 32'(imem_addr), 32'h11);
    do_reset();
    for (int i = 0; i < 5; i++) issue(6'd7, 10'h001, 8'h40, 4'h0, 0);
    @(posedge clk); #1;
    chk("stack_overflow", 32'({halt, illegal}), 32'h3);
    chk("overflow_pc", 32'(imem_addr), 32'd4);
`else
    do_reset();
    issue(6'd8, 10'h040, 8'h40, 4'h0, 0);
    @(posedge clk); #1;
    chk("ret_no_stack", 32'({halt, illegal}), 32'h3);
`endif

    for (int s = 0; s < 15; s++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        op = ($urandom_range(0, 15) < 12) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(0, 63));
        c  = ($urandom_range(0, 29) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        issue(op, 10'($urandom), c, 4'($urandom), $urandom_range(0, 3));
        if (last_fault) break;
      end
      repeat (3) begin
        imem_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    imem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
